// File: rtl/key_debounce_pkg.sv
// Shared constants and channel-state encoding for the key debounce block.
// The block's optional edge outputs are enabled by defining KEY_DEBOUNCE_EDGE_EN.
package key_debounce_pkg;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
   localparam int SIM_DEBOUNCE_CYCLES     = 4;

   typedef logic [0:0] chan_state_t;

   localparam chan_state_t STABLE   = 1'b0;
   localparam chan_state_t COUNTING = 1'b1;

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-flop synchronizer, stability counter and accept FSM.
// Defining KEY_DEBOUNCE_EDGE_EN adds registered press/release pulses.
module key_debounce_chan
   import key_debounce_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic IDLE_LEVEL      = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_raw,
`ifdef KEY_DEBOUNCE_EDGE_EN
   output logic press_pulse,
   output logic release_pulse,
`endif
   output logic key_db
);

   localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;
   chan_state_t      state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1         <= IDLE_LEVEL;
         sync2         <= IDLE_LEVEL;
         key_db        <= IDLE_LEVEL;
         cnt           <= '0;
         state         <= STABLE;
`ifdef KEY_DEBOUNCE_EDGE_EN
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
`endif
      end else begin
         sync1 <= key_raw;
         sync2 <= sync1;
`ifdef KEY_DEBOUNCE_EDGE_EN
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
`endif
         case (state)
            STABLE: begin
               if (sync2 != key_db) begin
                  state <= COUNTING;
                  cnt   <= CNT_W'(1);
               end else begin
                  cnt <= '0;
               end
            end
            COUNTING: begin
               // A bounce back to the accepted level discards the partial count.
               if (sync2 == key_db) begin
                  state <= STABLE;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  key_db <= sync2;
                  cnt    <= '0;
                  state  <= STABLE;
`ifdef KEY_DEBOUNCE_EDGE_EN
                  press_pulse   <= (sync2 != IDLE_LEVEL);
                  release_pulse <= (sync2 == IDLE_LEVEL);
`endif
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= STABLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/key_debounce_sync.sv
// Synchronizes and debounces raw KEY pins ahead of the key PIO in_port.
// Defining KEY_DEBOUNCE_EDGE_EN adds press_pulse/release_pulse outputs.
module key_debounce_sync
   import key_debounce_pkg::*;
#(
   parameter int   NUM_KEYS        = 2,
   parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic IDLE_LEVEL      = 1'b1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NUM_KEYS-1:0] key_raw,
`ifdef KEY_DEBOUNCE_EDGE_EN
   output logic [NUM_KEYS-1:0] press_pulse,
   output logic [NUM_KEYS-1:0] release_pulse,
`endif
   output logic [NUM_KEYS-1:0] key_db
);

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
      key_debounce_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .IDLE_LEVEL      (IDLE_LEVEL)
      ) u_chan (
         .clk           (clk),
         .reset_n       (reset_n),
         .key_raw       (key_raw[i]),
`ifdef KEY_DEBOUNCE_EDGE_EN
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i]),
`endif
         .key_db        (key_db[i])
      );
   end

endmodule

// File: tb/tb_key_debounce_sync.sv
// Bench for key_debounce_sync: vector table, directed corner sequences, random run.
module tb_key_debounce_sync;
   import key_debounce_pkg::*;

   localparam int NK = 2;
   localparam int DC = SIM_DEBOUNCE_CYCLES;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [NK-1:0] key_raw;
   logic [NK-1:0] key_db;
`ifdef KEY_DEBOUNCE_EDGE_EN
   logic [NK-1:0] press_pulse;
   logic [NK-1:0] release_pulse;
`endif

   key_debounce_sync #(
      .NUM_KEYS        (NK),
      .DEBOUNCE_CYCLES (DC),
      .IDLE_LEVEL      (1'b1)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .key_raw       (key_raw),
`ifdef KEY_DEBOUNCE_EDGE_EN
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
`endif
      .key_db        (key_db)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference: each key remembers the raw level seen two edges ago and the
   // length of the current run of samples that disagree with the accepted level.
   logic [NK-1:0] m_s1, m_s2, m_db, m_pp, m_rp;
   int            m_run [NK];

   typedef struct {
      logic [NK-1:0] raw;
      int            hold;
      logic [NK-1:0] exp_db;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_s1 = '1;
      m_s2 = '1;
      m_db = '1;
      m_pp = '0;
      m_rp = '0;
      for (int k = 0; k < NK; k++) m_run[k] = 0;
   endtask

   task automatic model_step();
      m_pp = '0;
      m_rp = '0;
      for (int k = 0; k < NK; k++) begin
         if (m_s2[k] != m_db[k]) begin
            m_run[k]++;
            if (m_run[k] == DC) begin
               m_db[k]  = m_s2[k];
               m_run[k] = 0;
               if (m_db[k]) m_rp[k] = 1'b1;
               else         m_pp[k] = 1'b1;
            end
         end else begin
            m_run[k] = 0;
         end
      end
      m_s2 = m_s1;
      m_s1 = key_raw;
   endtask

   task automatic tick();
      @(posedge clk);
      if (!reset_n) model_reset();
      else          model_step();
      #1;
      chk("model_db", 32'(key_db), 32'(m_db));
`ifdef KEY_DEBOUNCE_EDGE_EN
      chk("model_press", 32'(press_pulse), 32'(m_pp));
      chk("model_release", 32'(release_pulse), 32'(m_rp));
`endif
   endtask

   initial begin
      int hold [NK];

      vecs[0] = '{raw: 2'b11, hold: 10, exp_db: 2'b11};
      vecs[1] = '{raw: 2'b10, hold: 3,  exp_db: 2'b11};
      vecs[2] = '{raw: 2'b11, hold: 10, exp_db: 2'b11};
      vecs[3] = '{raw: 2'b10, hold: 4,  exp_db: 2'b11};
      vecs[4] = '{raw: 2'b10, hold: 2,  exp_db: 2'b10};
      vecs[5] = '{raw: 2'b00, hold: 6,  exp_db: 2'b00};
      vecs[6] = '{raw: 2'b01, hold: 6,  exp_db: 2'b01};
      vecs[7] = '{raw: 2'b11, hold: 5,  exp_db: 2'b01};
      vecs[8] = '{raw: 2'b11, hold: 1,  exp_db: 2'b11};

      // Reset and idle
      reset_n = 1'b0;
      key_raw = 2'b11;
      model_reset();
      repeat (3) tick();
      chk("reset_db", 32'(key_db), 32'h3);
`ifdef KEY_DEBOUNCE_EDGE_EN
      chk("reset_pulses", 32'({press_pulse, release_pulse}), 32'h0);
`endif
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("idle_db", 32'(key_db), 32'h3);
      end

      // Clean press on key 0: first visible after the sixth edge
      key_raw = 2'b10;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("press_wait_db", 32'(key_db), 32'h3);
      end
      tick();
      chk("press_db", 32'(key_db), 32'h2);
`ifdef KEY_DEBOUNCE_EDGE_EN
      chk("press_pulse_on", 32'(press_pulse), 32'h1);
`endif
      tick();
      chk("press_hold_db", 32'(key_db), 32'h2);
`ifdef KEY_DEBOUNCE_EDGE_EN
      chk("press_pulse_off", 32'(press_pulse), 32'h0);
`endif
      key_raw = 2'b11;
      repeat (5) tick();
      chk("release_wait_db", 32'(key_db), 32'h2);
      tick();
      chk("release_db", 32'(key_db), 32'h3);
`ifdef KEY_DEBOUNCE_EDGE_EN
      chk("release_pulse_on", 32'(release_pulse), 32'h1);
`endif

      // Bounce on key 0: 2-clock runs never accepted
      for (int i = 0; i < 20; i++) begin
         key_raw[0] = ((i / 2) % 2) == 1;
         tick();
         chk("bounce_db", 32'(key_db), 32'h3);
`ifdef KEY_DEBOUNCE_EDGE_EN
         chk("bounce_pulses", 32'({press_pulse, release_pulse}), 32'h0);
`endif
      end
      key_raw = 2'b11;
      repeat (8) tick();
      chk("bounce_settle_db", 32'(key_db), 32'h3);

      // Vector table: glitch of 3 rejected, 4+ accepted, per-key independence
      for (int v = 0; v < 9; v++) begin
         key_raw = vecs[v].raw;
         repeat (vecs[v].hold) tick();
         chk($sformatf("vec%0d_db", v), 32'(key_db), 32'(vecs[v].exp_db));
      end
      repeat (8) tick();

      // Both keys pressed together, key 1 released two clocks after key 0
      key_raw = 2'b00;
      repeat (5) tick();
      chk("both_wait_db", 32'(key_db), 32'h3);
      tick();
      chk("both_db", 32'(key_db), 32'h0);
      key_raw = 2'b01;
      repeat (2) tick();
      key_raw = 2'b11;
      repeat (3) tick();
      chk("stagger5_db", 32'(key_db), 32'h0);
      tick();
      chk("stagger6_db", 32'(key_db), 32'h1);
      tick();
      chk("stagger7_db", 32'(key_db), 32'h1);
      tick();
      chk("stagger8_db", 32'(key_db), 32'h3);
      repeat (4) tick();

      // Reset while key 0's counter is at 2, key held through release
      key_raw = 2'b10;
      repeat (4) tick();
      chk("precount_db", 32'(key_db), 32'h3);
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("async_reset_db", 32'(key_db), 32'h3);
      repeat (2) tick();
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("post_reset_wait_db", 32'(key_db), 32'h3);
      end
      tick();
      chk("post_reset_db", 32'(key_db), 32'h2);
      key_raw = 2'b11;
      repeat (8) tick();

      // Random levels with random hold times
      for (int k = 0; k < NK; k++) hold[k] = 1;
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < NK; k++) begin
            hold[k]--;
            if (hold[k] <= 0) begin
               key_raw[k] = 1'($urandom_range(0, 1));
               hold[k]    = int'($urandom_range(1, 9));
            end
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
